// File: rtl/lock_ctrl.sv
// lock_ctrl: keypad combination-lock sequencer. Collects code entries, opens the
// lock on a match, locks out after repeated failures and supports reprogramming.
module lock_ctrl #(
    parameter int                  DIGITS       = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 16'hB0B1,
    parameter int                  MAX_TRIES    = 3,
    parameter int                  UNLOCK_CYC   = 500,
    parameter int                  LOCKOUT_CYC  = 1000,
    parameter int                  ENTRY_TO     = 200
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           key_valid,
    input  logic [3:0]                     key_val,
    input  logic                           prog_req,
    output logic                           unlocked,
    output logic                           locked_out,
    output logic                           err_pulse,
    output logic                           prog_done,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt,
    output logic [$clog2(DIGITS+1)-1:0]    digit_cnt
);

    localparam int CW   = 4 * DIGITS;
    localparam int FW   = $clog2(MAX_TRIES + 1);
    localparam int DW   = $clog2(DIGITS + 1);
    localparam int TMAX = (UNLOCK_CYC > LOCKOUT_CYC) ?
                          ((UNLOCK_CYC > ENTRY_TO) ? UNLOCK_CYC : ENTRY_TO) :
                          ((LOCKOUT_CYC > ENTRY_TO) ? LOCKOUT_CYC : ENTRY_TO);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_MAX       = TW'(TMAX);
    localparam logic [TW-1:0] ENTRY_LAST  = TW'(ENTRY_TO - 1);
    localparam logic [TW-1:0] UNLOCK_LAST = TW'(UNLOCK_CYC - 1);
    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCKOUT_CYC - 1);
    localparam logic [DW-1:0] LAST_DIGIT  = DW'(DIGITS - 1);
    localparam logic [DW-1:0] DIGIT_MAX   = DW'(DIGITS);
    localparam logic [FW-1:0] FAIL_MAX    = FW'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_PROG    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t          state_r, state_next_s;
    logic [TW-1:0]   timer_r, timer_next_s;
    logic [CW-1:0]   entry_r, entry_next_s, code_r, code_next_s, shifted_s;
    logic [DW-1:0]   digit_cnt_r, digit_next_s;
    logic [FW-1:0]   fail_cnt_r, fail_next_s, fail_inc_s;
    logic            unlocked_r, locked_out_r, err_pulse_r, prog_done_r;
    logic            err_next_s, prog_done_next_s;
    logic            timer_done_s, take_key_s, last_key_s, match_s;
    logic            clear_s, commit_s;

    assign last_key_s = (digit_cnt_r == LAST_DIGIT);
    assign shifted_s  = CW'({entry_r, key_val});
    assign match_s    = (entry_r == code_r);
    assign fail_inc_s = (fail_cnt_r < FAIL_MAX) ? (fail_cnt_r + FW'(1)) : fail_cnt_r;

    // Timer expiry per state and key acceptance; an expiring timer drops a coincident key.
    always_comb begin
        timer_done_s = 1'b0;
        take_key_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                timer_done_s = 1'b0;
                take_key_s   = key_valid;
            end
            S_ENTRY, S_PROG: begin
                timer_done_s = (timer_r == ENTRY_LAST);
                take_key_s   = key_valid && (timer_r != ENTRY_LAST);
            end
            S_OPEN: begin
                timer_done_s = (timer_r == UNLOCK_LAST);
                take_key_s   = key_valid && prog_req && (timer_r != UNLOCK_LAST);
            end
            S_LOCKOUT: begin
                timer_done_s = (timer_r == LOCK_LAST);
                take_key_s   = 1'b0;
            end
            default: begin
                timer_done_s = 1'b0;
                take_key_s   = 1'b0;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (take_key_s) state_next_s = last_key_s ? S_CHECK : S_ENTRY;
                else            state_next_s = S_IDLE;
            end
            S_ENTRY: begin
                if (timer_done_s)                  state_next_s = S_IDLE;
                else if (take_key_s && last_key_s) state_next_s = S_CHECK;
                else                               state_next_s = S_ENTRY;
            end
            S_CHECK: begin
                if (match_s)                     state_next_s = S_OPEN;
                else if (fail_inc_s == FAIL_MAX) state_next_s = S_LOCKOUT;
                else                             state_next_s = S_IDLE;
            end
            S_OPEN: begin
                if (timer_done_s)    state_next_s = S_IDLE;
                else if (take_key_s) state_next_s = last_key_s ? S_IDLE : S_PROG;
                else                 state_next_s = S_OPEN;
            end
            S_PROG: begin
                if (timer_done_s)                  state_next_s = S_IDLE;
                else if (take_key_s && last_key_s) state_next_s = S_IDLE;
                else                               state_next_s = S_PROG;
            end
            S_LOCKOUT: begin
                if (timer_done_s) state_next_s = S_IDLE;
                else              state_next_s = S_LOCKOUT;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Datapath and output next values; the entry clears whenever CHECK ends or we fall back to IDLE.
    always_comb begin
        clear_s      = (state_r == S_CHECK) || ((state_next_s == S_IDLE) && (state_r != S_IDLE));
        commit_s     = take_key_s && last_key_s && ((state_r == S_PROG) || (state_r == S_OPEN));
        timer_next_s = (take_key_s || (state_next_s != state_r)) ? {TW{1'b0}} :
                       ((timer_r < T_MAX) ? (timer_r + TW'(1)) : timer_r);
        entry_next_s = clear_s ? {CW{1'b0}} : (take_key_s ? shifted_s : entry_r);
        digit_next_s = clear_s ? {DW{1'b0}} :
                       ((take_key_s && (digit_cnt_r < DIGIT_MAX)) ? (digit_cnt_r + DW'(1)) : digit_cnt_r);
        code_next_s      = commit_s ? shifted_s : code_r;
        prog_done_next_s = commit_s;
        fail_next_s      = fail_cnt_r;
        err_next_s       = 1'b0;
        case (state_r)
            S_CHECK: begin
                fail_next_s = match_s ? {FW{1'b0}} : fail_inc_s;
                err_next_s  = !match_s;
            end
            S_LOCKOUT: begin
                fail_next_s = timer_done_s ? {FW{1'b0}} : fail_cnt_r;
                err_next_s  = 1'b0;
            end
            default: begin
                fail_next_s = fail_cnt_r;
                err_next_s  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_IDLE;
        else        state_r <= state_next_s;
    end

    // Counters, code store and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r      <= {TW{1'b0}};
            entry_r      <= {CW{1'b0}};
            code_r       <= DEFAULT_CODE;
            digit_cnt_r  <= {DW{1'b0}};
            fail_cnt_r   <= {FW{1'b0}};
            unlocked_r   <= 1'b0;
            locked_out_r <= 1'b0;
            err_pulse_r  <= 1'b0;
            prog_done_r  <= 1'b0;
        end else begin
            timer_r      <= timer_next_s;
            entry_r      <= entry_next_s;
            code_r       <= code_next_s;
            digit_cnt_r  <= digit_next_s;
            fail_cnt_r   <= fail_next_s;
            unlocked_r   <= (state_next_s == S_OPEN);
            locked_out_r <= (state_next_s == S_LOCKOUT);
            err_pulse_r  <= err_next_s;
            prog_done_r  <= prog_done_next_s;
        end
    end

    assign unlocked   = unlocked_r;
    assign locked_out = locked_out_r;
    assign err_pulse  = err_pulse_r;
    assign prog_done  = prog_done_r;
    assign fail_cnt   = fail_cnt_r;
    assign digit_cnt  = digit_cnt_r;

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: directed scenarios plus random key traffic, every cycle
// compared against a deadline-based reference model of the lock.
module tb_lock_ctrl;

    localparam int          DIGITS       = 4;
    localparam logic [15:0] DEFAULT_CODE = 16'hB0B1;
    localparam int          MAX_TRIES    = 3;
    localparam int          UNLOCK_CYC   = 10;
    localparam int          LOCKOUT_CYC  = 20;
    localparam int          ENTRY_TO     = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_val;
    logic       prog_req;
    logic       unlocked, locked_out, err_pulse, prog_done;
    logic [1:0] fail_cnt;
    logic [2:0] digit_cnt;

    lock_ctrl #(
        .DIGITS      (DIGITS),
        .DEFAULT_CODE(DEFAULT_CODE),
        .MAX_TRIES   (MAX_TRIES),
        .UNLOCK_CYC  (UNLOCK_CYC),
        .LOCKOUT_CYC (LOCKOUT_CYC),
        .ENTRY_TO    (ENTRY_TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_val   (key_val),
        .prog_req  (prog_req),
        .unlocked  (unlocked),
        .locked_out(locked_out),
        .err_pulse (err_pulse),
        .prog_done (prog_done),
        .fail_cnt  (fail_cnt),
        .digit_cnt (digit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: entered digits in a queue, unlock/lockout as absolute deadlines.
    logic [15:0] m_code;
    logic [15:0] m_pend_val;
    int          q[$];
    bit          m_prog, m_open, m_lock, m_pend, e_err, e_pd;
    int          m_fail, m_last_key, m_open_end, m_lock_end, m_edge;
    int          unl_hi, lock_hi, pd_seen, err_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_code = DEFAULT_CODE;
        q.delete();
        m_prog = 0; m_open = 0; m_lock = 0; m_pend = 0; e_err = 0; e_pd = 0;
        m_fail = 0; m_last_key = 0; m_open_end = 0; m_lock_end = 0; m_edge = 0;
        m_pend_val = 16'h0000;
    endtask

    task automatic model_step(input bit kv, input int kval, input bit preq);
        logic [15:0] v;
        m_edge++;
        e_err = 0;
        e_pd  = 0;
        if (m_pend) begin
            m_pend = 0;
            if (m_pend_val == m_code) begin
                m_open = 1; m_open_end = m_edge + UNLOCK_CYC; m_fail = 0;
            end else begin
                e_err = 1;
                m_fail++;
                if (m_fail == MAX_TRIES) begin
                    m_lock = 1; m_lock_end = m_edge + LOCKOUT_CYC;
                end
            end
        end else if (m_lock) begin
            if (m_edge == m_lock_end) begin
                m_lock = 0; m_fail = 0;
            end
        end else if (m_open) begin
            if (m_edge == m_open_end) m_open = 0;
            else if (kv && preq) begin
                m_open = 0; m_prog = 1; q = {kval}; m_last_key = m_edge;
            end
        end else if (q.size() > 0 && (m_edge - m_last_key) == ENTRY_TO) begin
            q.delete();
            m_prog = 0;
        end else if (kv) begin
            q.push_back(kval);
            m_last_key = m_edge;
            if (q.size() == DIGITS) begin
                v = 16'h0000;
                foreach (q[i]) v = (v << 4) | 16'(q[i]);
                if (m_prog) begin
                    m_code = v; e_pd = 1; m_prog = 0;
                end else begin
                    m_pend = 1; m_pend_val = v;
                end
                q.delete();
            end
        end
    endtask

    task automatic tick(input bit kv, input logic [3:0] kval, input bit preq);
        key_valid = kv;
        key_val   = kval;
        prog_req  = preq;
        @(posedge clk);
        model_step(kv, int'(kval), preq);
        @(negedge clk);
        key_valid = 1'b0;
        chk("unlocked",   32'(unlocked),   32'(m_open));
        chk("locked_out", 32'(locked_out), 32'(m_lock));
        chk("err_pulse",  32'(err_pulse),  32'(e_err));
        chk("prog_done",  32'(prog_done),  32'(e_pd));
        chk("fail_cnt",   32'(fail_cnt),   32'(m_fail));
        chk("digit_cnt",  32'(digit_cnt),  m_pend ? 32'(DIGITS) : 32'(q.size()));
        unl_hi   += int'(unlocked);
        lock_hi  += int'(locked_out);
        pd_seen  += int'(prog_done);
        err_seen += int'(err_pulse);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 1'b0);
    endtask

    task automatic enter(input logic [15:0] code, input bit preq);
        for (int i = DIGITS - 1; i >= 0; i--) tick(1'b1, code[4*i +: 4], preq);
    endtask

    task automatic do_reset();
        key_valid = 1'b0;
        key_val   = 4'h0;
        prog_req  = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_unlocked",   32'(unlocked),   32'd0);
        chk("rst_locked_out", 32'(locked_out), 32'd0);
        chk("rst_err_pulse",  32'(err_pulse),  32'd0);
        chk("rst_prog_done",  32'(prog_done),  32'd0);
        chk("rst_fail_cnt",   32'(fail_cnt),   32'd0);
        chk("rst_digit_cnt",  32'(digit_cnt),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int nd;
        rst_n = 1'b1; key_valid = 1'b0; key_val = 4'h0; prog_req = 1'b0;
        unl_hi = 0; lock_hi = 0; pd_seen = 0; err_seen = 0;
        #2;
        do_reset();

        // Correct code: unlock two cycles after the last key, held UNLOCK_CYC cycles.
        unl_hi = 0;
        enter(16'hB0B1, 1'b0);
        chk("unl_in_check", 32'(unlocked), 32'd0);
        idle(1);
        chk("unl_rise", 32'(unlocked), 32'd1);
        idle(14);
        chk("unlock_len", 32'(unl_hi), 32'(UNLOCK_CYC));

        // Three failures -> lockout that ignores the correct code.
        for (int i = 0; i < 2; i++) begin
            enter(16'h1234, 1'b0);
            idle(2);
        end
        chk("fail_two", 32'(fail_cnt), 32'd2);
        lock_hi = 0; unl_hi = 0;
        enter(16'h1234, 1'b0);
        enter(16'hB0B1, 1'b0);
        idle(25);
        chk("lock_len", 32'(lock_hi), 32'(LOCKOUT_CYC));
        chk("lock_no_unlock", 32'(unl_hi), 32'd0);
        chk("lock_fail_clr", 32'(fail_cnt), 32'd0);
        enter(16'hB0B1, 1'b0);
        idle(12);

        // Partial entry times out without counting as a failure.
        err_seen = 0;
        tick(1'b1, 4'hB, 1'b0);
        tick(1'b1, 4'h0, 1'b0);
        idle(ENTRY_TO - 1);
        chk("to_before", 32'(digit_cnt), 32'd2);
        idle(1);
        chk("to_expired", 32'(digit_cnt), 32'd0);
        chk("to_no_err", 32'(err_seen), 32'd0);
        enter(16'hB0B1, 1'b0);
        idle(12);

        // Program a new code while open.
        enter(16'hB0B1, 1'b0);
        idle(2);
        pd_seen = 0;
        enter(16'h7359, 1'b1);
        chk("prog_pulse", 32'(prog_done), 32'd1);
        chk("prog_unl", 32'(unlocked), 32'd0);
        idle(2);
        chk("prog_once", 32'(pd_seen), 32'd1);
        err_seen = 0;
        enter(16'hB0B1, 1'b0);
        idle(2);
        chk("old_code_err", 32'(err_seen), 32'd1);
        enter(16'h7359, 1'b0);
        idle(2);
        chk("new_code_unl", 32'(unlocked), 32'd1);
        idle(10);

        // Reset in the middle of programming restores the default code.
        enter(16'h7359, 1'b0);
        idle(2);
        tick(1'b1, 4'h7, 1'b1);
        tick(1'b1, 4'h3, 1'b1);
        chk("prog_partial", 32'(digit_cnt), 32'd2);
        do_reset();
        enter(16'hB0B1, 1'b0);
        idle(1);
        chk("post_rst_unl", 32'(unlocked), 32'd1);
        idle(12);

        // A match clears the failure count.
        enter(16'h1234, 1'b0); idle(1);
        enter(16'h1234, 1'b0); idle(1);
        chk("fail_pre", 32'(fail_cnt), 32'd2);
        enter(16'hB0B1, 1'b0); idle(1);
        chk("match_unl", 32'(unlocked), 32'd1);
        chk("match_fail_clr", 32'(fail_cnt), 32'd0);
        idle(12);
        enter(16'h1234, 1'b0); idle(1);
        chk("fail_one", 32'(fail_cnt), 32'd1);
        chk("no_lockout", 32'(locked_out), 32'd0);
        idle(3);

        // Random traffic against the model.
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 5))
                0: enter(m_code, 1'($urandom_range(0, 1)));
                1: enter(16'($urandom), 1'b0);
                2: begin
                    nd = $urandom_range(1, 3);
                    for (int d = 0; d < nd; d++) tick(1'b1, 4'($urandom), 1'b0);
                    idle($urandom_range(0, 10));
                end
                3: idle($urandom_range(0, 12));
                4: enter(16'($urandom), 1'b1);
                default: begin
                    for (int d = 0; d < 6; d++)
                        tick(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
